uart_reg_master: RTL and testbench
==================================

// Module: uart_reg_master
// PURPOSE
// - Sole owner of the uart_16750 register bus (cs/wr/rd/a/din/dout) in the clk_33M domain.
// - After reset, runs a fixed init sequence: 8N1, baud divisor, FIFO, IER. Then shares the bus
//   between an RX poller (LSR.DR -> RBR) and a TX writer (LSR.THRE -> THR).
// - Exposes bytes to fabric as valid/ready streams. Replaces ad-hoc config/poll FSMs in top.
// PARAMETERS
// - DIVISOR  16'h0011  baud divisor, written as DLL (low byte) then DLM (high byte)
// - LCR_VAL  8'h03     LCR value written after the divisor (DLAB=0)
// - FCR_VAL  8'h81     FCR value (FIFO enable, trigger level)
// - IER_VAL  8'h00     IER value written last
// PORTS
// - clk          in   1  UART/register clock (clk_33M)
// - rst          in   1  async reset, active-high
// - uart_cs      out  1  chip select to uart_16750
// - uart_wr      out  1  write strobe
// - uart_rd      out  1  read strobe
// - uart_a       out  3  register address
// - uart_din     out  8  write data to UART
// - uart_dout    in   8  read data from UART
// - init_done    out  1  high once init completes; stays high until rst
// - rx_data      out  8  received byte
// - rx_valid     out  1  rx_data valid; held until rx_ready
// - rx_ready     in   1  consumer accepts rx_data
// - tx_data      in   8  byte to send; must stay stable while tx_valid && !tx_ready
// - tx_valid     in   1  byte pending
// - tx_ready     out  1  1-cycle pulse: tx_data written to THR (transfer complete)
// - rx_overrun   out  1  sticky: LSR.OE (bit1) seen during any LSR read
// - ovr_clr      in   1  clears rx_overrun; if set and clear coincide, set wins
// BEHAVIOUR
// - Reset: all outputs 0, FSM in INIT_LCR_DLAB, bus idle. rst mid-access drops cs/wr/rd at once.
// - Bus access is 3 cycles: S (cs=1, a/din valid, wr=rd=0), P (wr or rd=1), R (cs=wr=rd=0).
//   Read data: uart_dout sampled at the clock edge that ends P. Bus never idles >1 cycle
//   between accesses except in IDLE.
// - Init FSM, one write each: INIT_LCR_DLAB (LCR=LCR_VAL|8'h80) -> INIT_DLL -> INIT_DLM
//   -> INIT_LCR (LCR_VAL) -> INIT_FCR -> INIT_IER -> IDLE.
//   init_done rises in the cycle after the R phase of the IER write (cycle 19 after reset release).
//   No RX/TX activity before init_done. tx_valid during init is held off (tx_ready stays 0).
// - Service FSM: IDLE -> RX_LSR -> (DR ? RX_RBR : IDLE); IDLE -> TX_LSR -> (THRE ? TX_THR : IDLE).
//   - RX eligible when rx_valid=0. TX eligible when tx_valid=1.
//   - Both eligible: round-robin via last_grant bit, flipped on every grant. First grant after
//     init goes to RX.
//   - Neither eligible: stay in IDLE, bus idle.
// - RX_RBR: rx_data <= sampled byte; rx_valid=1 from the cycle after R until rx_valid&&rx_ready.
//   No further RX poll while rx_valid=1, so the UART FIFO provides buffering.
// - TX_THR: writes tx_data; tx_ready pulses in the R cycle. THRE=0 at LSR -> yield to IDLE, retry later.
// - Every LSR read (RX or TX path) ORs bit1 into rx_overrun.
// - LSR bit masks: DR=bit0, OE=bit1, THRE=bit5. Addresses: RBR/THR/DLL=0, IER/DLM=1,
//   FCR=2, LCR=3, LSR=5.
// - Exactly one of wr/rd may be high, and only while cs=1. Assertion required.
// STRUCTURE
// - Package uart16750_pkg: register address localparams, LSR bit indices, FSM state enum
//   (4-bit encoding).
// - Sub-module uart_bus_access: 3-phase S/P/R engine.
//   - Inputs: req, we, addr, wdata.
//   - Outputs: done (pulse in R), rdata (registered), cs/wr/rd/a/din.
// - Top-level FSM issues one req per state and advances on done.
// TESTING
// - Reset release, bus-functional UART model -> writes observed in order: LCR=83, DLL=11,
//   DLM=00, LCR=03, FCR=81, IER=00. init_done=1 at cycle 19.
// - Model LSR=01, RBR=0x20, rx_ready=0 -> rx_valid=1, rx_data=0x20. No further LSR/RBR
//   reads until rx_ready pulse.
// - tx_valid=1, tx_data=0x55, model LSR=0x00 three times then 0x20 -> THR write of 0x55 and a
//   single tx_ready pulse. No THR write before that.
// - RX and TX continuously eligible -> grants alternate RX, TX, RX, TX. First grant is RX.
// - Model LSR=0x03 on a read with ovr_clr=1 in the same cycle -> rx_overrun=1. A later ovr_clr
//   alone -> rx_overrun=0.
// - Assert rst during P phase of the DLM write -> cs/wr drop immediately. After release, init
//   restarts from LCR=83.

Source files
------------

// File: rtl/uart16750_pkg.sv
// ============================================================================
// Module   : uart16750_pkg
// Purpose  : Register map, LSR bit positions and state encodings shared by
//            the uart_16750 register-bus master and its bus engine.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart16750_pkg;

  // uart_16750 register addresses (several share an offset, selected by DLAB
  // or by direction)
  localparam logic [2:0] C_ADDR_RBR = 3'd0;
  localparam logic [2:0] C_ADDR_THR = 3'd0;
  localparam logic [2:0] C_ADDR_DLL = 3'd0;
  localparam logic [2:0] C_ADDR_IER = 3'd1;
  localparam logic [2:0] C_ADDR_DLM = 3'd1;
  localparam logic [2:0] C_ADDR_FCR = 3'd2;
  localparam logic [2:0] C_ADDR_LCR = 3'd3;
  localparam logic [2:0] C_ADDR_LSR = 3'd5;

  // Line status register bit positions
  localparam int C_LSR_DR   = 0;
  localparam int C_LSR_OE   = 1;
  localparam int C_LSR_THRE = 5;

  // Round-robin arbiter: value of last_grant after each kind of grant
  localparam logic C_GRANT_RX = 1'b0;
  localparam logic C_GRANT_TX = 1'b1;

  // Master FSM: init sequence, then the shared RX/TX service loop
  typedef enum logic [3:0] {
    ST_INIT_LCR_DLAB = 4'd0,
    ST_INIT_DLL      = 4'd1,
    ST_INIT_DLM      = 4'd2,
    ST_INIT_LCR      = 4'd3,
    ST_INIT_FCR      = 4'd4,
    ST_INIT_IER      = 4'd5,
    ST_IDLE          = 4'd6,
    ST_RX_LSR        = 4'd7,
    ST_RX_RBR        = 4'd8,
    ST_TX_LSR        = 4'd9,
    ST_TX_THR        = 4'd10
  } state_e;

  // Bus engine phases: setup, pulse, release
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_S    = 2'd1,
    PH_P    = 2'd2,
    PH_R    = 2'd3
  } phase_e;

endpackage

`default_nettype wire

// File: rtl/uart_bus_access.sv
// ============================================================================
// Module   : uart_bus_access
// Purpose  : Three-phase (S/P/R) access engine for the uart_16750 register
//            bus. A request accepted while idle or in R starts the next
//            access immediately, so back-to-back accesses leave no gap.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_bus_access
  import uart16750_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [2:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       cs_o,
  output logic       wr_o,
  output logic       rd_o,
  output logic [2:0] a_o,
  output logic [7:0] din_o,
  input  logic [7:0] dout_i
);

  phase_e     phase_q;
  logic       we_q;
  logic       cs_q;
  logic       wr_q;
  logic       rd_q;
  logic [2:0] a_q;
  logic [7:0] din_q;
  logic [7:0] rdata_q;

  // Phase sequencer; all bus pins are registered and drop at once on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      we_q    <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      a_q     <= 3'd0;
      din_q   <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      case (phase_q)
        PH_S: begin
          phase_q <= PH_P;
          wr_q    <= we_q;
          rd_q    <= ~we_q;
        end
        PH_P: begin
          phase_q <= PH_R;
          cs_q    <= 1'b0;
          wr_q    <= 1'b0;
          rd_q    <= 1'b0;
          if (!we_q) begin
            rdata_q <= dout_i;
          end
        end
        default: begin
          if (req_i) begin
            phase_q <= PH_S;
            cs_q    <= 1'b1;
            a_q     <= addr_i;
            din_q   <= wdata_i;
            we_q    <= we_i;
          end else begin
            phase_q <= PH_IDLE;
          end
        end
      endcase
    end
  end

  assign done_o  = (phase_q == PH_R);
  assign rdata_o = rdata_q;
  assign cs_o    = cs_q;
  assign wr_o    = wr_q;
  assign rd_o    = rd_q;
  assign a_o     = a_q;
  assign din_o   = din_q;

endmodule

`default_nettype wire

// File: rtl/uart_reg_master.sv
// ============================================================================
// Module   : uart_reg_master
// Purpose  : Owns the uart_16750 register bus. Runs the line/baud/FIFO/IER
//            init sequence, then round-robins an RX poller (LSR.DR -> RBR)
//            and a TX writer (LSR.THRE -> THR), exposing valid/ready streams.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_reg_master
  import uart16750_pkg::*;
#(
  parameter logic [15:0] DIVISOR = 16'h0011,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter logic [7:0]  FCR_VAL = 8'h81,
  parameter logic [7:0]  IER_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic       uart_cs,
  output logic       uart_wr,
  output logic       uart_rd,
  output logic [2:0] uart_a,
  output logic [7:0] uart_din,
  input  logic [7:0] uart_dout,
  output logic       init_done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rx_overrun,
  input  logic       ovr_clr
);

  state_e     state_q;
  state_e     state_d;
  state_e     w_tgt;
  logic       last_grant_q;
  logic       init_done_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_ready_q;
  logic       rx_overrun_q;

  logic       w_req;
  logic       w_we;
  logic [2:0] w_addr;
  logic [7:0] w_wdata;
  logic       w_done;
  logic [7:0] w_rdata;
  logic       w_rx_elig;
  logic       w_tx_elig;
  logic       w_ovr_set;

  assign w_rx_elig = ~rx_valid_q;
  assign w_tx_elig = tx_valid;
  assign w_ovr_set = uart_rd && (uart_a == C_ADDR_LSR) && uart_dout[C_LSR_OE];

  // Next state: access states advance on done; IDLE arbitrates round-robin
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT_LCR_DLAB: if (w_done) state_d = ST_INIT_DLL;
      ST_INIT_DLL:      if (w_done) state_d = ST_INIT_DLM;
      ST_INIT_DLM:      if (w_done) state_d = ST_INIT_LCR;
      ST_INIT_LCR:      if (w_done) state_d = ST_INIT_FCR;
      ST_INIT_FCR:      if (w_done) state_d = ST_INIT_IER;
      ST_INIT_IER:      if (w_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (w_rx_elig && (!w_tx_elig || (last_grant_q == C_GRANT_TX))) begin
          state_d = ST_RX_LSR;
        end else if (w_tx_elig) begin
          state_d = ST_TX_LSR;
        end
      end
      ST_RX_LSR: if (w_done) state_d = w_rdata[C_LSR_DR] ? ST_RX_RBR : ST_IDLE;
      ST_RX_RBR: if (w_done) state_d = ST_IDLE;
      ST_TX_LSR: if (w_done) state_d = w_rdata[C_LSR_THRE] ? ST_TX_THR : ST_IDLE;
      ST_TX_THR: if (w_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The access for the upcoming state is presented during R (and during the
  // IDLE grant cycle) so the engine can chain accesses with no idle gap
  always_comb begin
    w_tgt = (w_done || (state_q == ST_IDLE)) ? state_d : state_q;
    w_req   = 1'b1;
    w_we    = 1'b1;
    w_addr  = 3'd0;
    w_wdata = 8'h00;
    case (w_tgt)
      ST_INIT_LCR_DLAB: begin w_addr = C_ADDR_LCR; w_wdata = LCR_VAL | 8'h80; end
      ST_INIT_DLL:      begin w_addr = C_ADDR_DLL; w_wdata = DIVISOR[7:0];    end
      ST_INIT_DLM:      begin w_addr = C_ADDR_DLM; w_wdata = DIVISOR[15:8];   end
      ST_INIT_LCR:      begin w_addr = C_ADDR_LCR; w_wdata = LCR_VAL;         end
      ST_INIT_FCR:      begin w_addr = C_ADDR_FCR; w_wdata = FCR_VAL;         end
      ST_INIT_IER:      begin w_addr = C_ADDR_IER; w_wdata = IER_VAL;         end
      ST_RX_LSR:        begin w_addr = C_ADDR_LSR; w_we = 1'b0;               end
      ST_TX_LSR:        begin w_addr = C_ADDR_LSR; w_we = 1'b0;               end
      ST_RX_RBR:        begin w_addr = C_ADDR_RBR; w_we = 1'b0;               end
      ST_TX_THR:        begin w_addr = C_ADDR_THR; w_wdata = tx_data;         end
      default:          begin w_req = 1'b0; w_we = 1'b0;                      end
    endcase
  end

  uart_bus_access u_bus (
    .clk     (clk),
    .rst     (rst),
    .req_i   (w_req),
    .we_i    (w_we),
    .addr_i  (w_addr),
    .wdata_i (w_wdata),
    .done_o  (w_done),
    .rdata_o (w_rdata),
    .cs_o    (uart_cs),
    .wr_o    (uart_wr),
    .rd_o    (uart_rd),
    .a_o     (uart_a),
    .din_o   (uart_din),
    .dout_i  (uart_dout)
  );

  // FSM state and registered stream/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT_LCR_DLAB;
      last_grant_q <= C_GRANT_TX;
      init_done_q  <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      tx_ready_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if ((state_q == ST_INIT_IER) && w_done) begin
        init_done_q <= 1'b1;
      end

      if (state_q == ST_IDLE) begin
        if (state_d == ST_RX_LSR) begin
          last_grant_q <= C_GRANT_RX;
        end else if (state_d == ST_TX_LSR) begin
          last_grant_q <= C_GRANT_TX;
        end
      end

      if ((state_q == ST_RX_RBR) && w_done) begin
        rx_data_q  <= w_rdata;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      // Write pulse of the THR access is in P, so this lands in R
      tx_ready_q <= (state_q == ST_TX_THR) && uart_wr;

      if (w_ovr_set) begin
        rx_overrun_q <= 1'b1;
      end else if (ovr_clr) begin
        rx_overrun_q <= 1'b0;
      end
    end
  end

  assign init_done  = init_done_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign tx_ready   = tx_ready_q;
  assign rx_overrun = rx_overrun_q;

  // Strobes are mutually exclusive and only ever asserted under chip select
  a_bus_strobes : assert property (@(posedge clk) disable iff (rst)
    !(uart_wr && uart_rd) && (!(uart_wr || uart_rd) || uart_cs));

endmodule

`default_nettype wire

// File: tb/tb_uart_reg_master.sv
// ============================================================================
// Module   : tb_uart_reg_master
// Purpose  : Directed self-checking bench for uart_reg_master with a small
//            bus-functional uart_16750 model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_reg_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_cs, uart_wr, uart_rd;
  logic [2:0] uart_a;
  logic [7:0] uart_din;
  logic [7:0] uart_dout;
  logic       init_done;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       rx_overrun, ovr_clr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_reg_master dut (
    .clk        (clk),
    .rst        (rst),
    .uart_cs    (uart_cs),
    .uart_wr    (uart_wr),
    .uart_rd    (uart_rd),
    .uart_a     (uart_a),
    .uart_din   (uart_din),
    .uart_dout  (uart_dout),
    .init_done  (init_done),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_overrun (rx_overrun),
    .ovr_clr    (ovr_clr)
  );

  // UART model: LSR either fixed or "0x00 for three reads, then THRE"
  logic [7:0] lsr_val, rbr_val;
  bit         tx_seq_mode;
  int         lsr_base;
  int         lsr_reads  = 0;
  int         tx_pulses  = 0;
  int         tx_early   = 0;

  always_comb begin
    uart_dout = 8'h00;
    if (uart_a == 3'd5) begin
      if (tx_seq_mode) uart_dout = ((lsr_reads - lsr_base) <= 3) ? 8'h00 : 8'h20;
      else             uart_dout = lsr_val;
    end else if (uart_a == 3'd0) begin
      uart_dout = rbr_val;
    end
  end

  typedef struct {
    bit       wr;
    bit [2:0] a;
    bit [7:0] d;
    int       lsrn;
  } acc_t;

  acc_t acc_log[$];
  acc_t log_e;

  // Log each access once, in its P cycle
  always @(negedge clk) begin
    if (uart_cs && uart_wr) begin
      log_e.wr = 1'b1; log_e.a = uart_a; log_e.d = uart_din; log_e.lsrn = lsr_reads;
      acc_log.push_back(log_e);
    end
    if (uart_cs && uart_rd) begin
      if (uart_a == 3'd5) lsr_reads++;
      log_e.wr = 1'b0; log_e.a = uart_a; log_e.d = uart_dout; log_e.lsrn = lsr_reads;
      acc_log.push_back(log_e);
    end
    if (tx_ready) tx_pulses++;
    if (tx_ready && !init_done) tx_early++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [11:0] exp_init [6];
  logic [3:0]  exp_rr   [8];

  initial begin
    int  n0, nthr, thr_idx, pbase;
    bit  ok;

    // {wr, a, data} of the init writes
    exp_init[0] = 12'hB83; exp_init[1] = 12'h811; exp_init[2] = 12'h900;
    exp_init[3] = 12'hB03; exp_init[4] = 12'hA81; exp_init[5] = 12'h900;
    // {wr, a}: RX LSR, RBR, TX LSR, THR, repeated
    exp_rr[0] = 4'h5; exp_rr[1] = 4'h0; exp_rr[2] = 4'h5; exp_rr[3] = 4'h8;
    exp_rr[4] = 4'h5; exp_rr[5] = 4'h0; exp_rr[6] = 4'h5; exp_rr[7] = 4'h8;

    // ---- Phase 1: reset, init, round-robin with both sides eligible ----
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h3C; rx_ready = 1'b1; ovr_clr = 1'b0;
    lsr_val = 8'h21; rbr_val = 8'h7E; tx_seq_mode = 1'b0; lsr_base = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs", uart_cs, 0);
    check_eq("rst_wr", uart_wr, 0);
    check_eq("rst_rd", uart_rd, 0);
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_tx_ready", tx_ready, 0);
    check_eq("rst_overrun", rx_overrun, 0);
    n0 = acc_log.size();
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 1) begin
        check_eq("c1_cs", uart_cs, 1);
        check_eq("c1_a", uart_a, 3);
      end
      if (k == 18) check_eq("init_done_c18", init_done, 0);
      if (k == 19) check_eq("init_done_c19", init_done, 1);
    end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (acc_log.size() >= n0 + 14) begin ok = 1'b1; break; end
      tick();
    end
    check_eq("p1_log_timeout", ok, 1);
    if (ok) begin
      for (int i = 0; i < 6; i++)
        check_eq("init_write", {acc_log[n0+i].wr, acc_log[n0+i].a, acc_log[n0+i].d}, exp_init[i]);
      for (int i = 0; i < 8; i++)
        check_eq("rr_grant", {acc_log[n0+6+i].wr, acc_log[n0+6+i].a}, exp_rr[i]);
      check_eq("rr_thr_data", acc_log[n0+9].d, 8'h3C);
    end
    check_eq("tx_ready_before_init", tx_early, 0);

    // ---- Phase 2: RX byte held while rx_ready=0, no further polling ----
    rst = 1'b1; tx_valid = 1'b0; rx_ready = 1'b0; lsr_val = 8'h01; rbr_val = 8'h20;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rx_valid) begin ok = 1'b1; break; end
    end
    check_eq("rx_valid_timeout", ok, 1);
    check_eq("rx_data", rx_data, 8'h20);
    n0 = acc_log.size();
    repeat (40) tick();
    check_eq("rx_hold_no_poll", acc_log.size() - n0, 0);
    check_eq("rx_valid_held", rx_valid, 1);

    // ---- Phase 3: TX retries until THRE, single THR write and pulse ----
    lsr_base = lsr_reads; tx_seq_mode = 1'b1; pbase = tx_pulses; n0 = acc_log.size();
    tx_data = 8'h55; tx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx_ready) begin ok = 1'b1; tx_valid = 1'b0; break; end
    end
    check_eq("tx_ready_timeout", ok, 1);
    repeat (20) tick();
    check_eq("tx_ready_pulses", tx_pulses - pbase, 1);
    nthr = 0; thr_idx = 0;
    for (int i = n0; i < acc_log.size(); i++) begin
      if (acc_log[i].wr && acc_log[i].a == 3'd0) begin nthr++; thr_idx = i; end
    end
    check_eq("thr_write_count", nthr, 1);
    if (nthr > 0) begin
      check_eq("thr_data", acc_log[thr_idx].d, 8'h55);
      check_eq("thr_after_lsr_n", acc_log[thr_idx].lsrn - lsr_base, 4);
    end
    check_eq("tx_lsr_reads", lsr_reads - lsr_base, 4);

    // ---- Phase 4: overrun set beats coincident clear, later clear ----
    tx_seq_mode = 1'b0; lsr_val = 8'h03;
    check_eq("ovr_initial", rx_overrun, 0);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check_eq("rx_ready_accept", rx_valid, 0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (uart_rd && uart_a == 3'd5) begin
        ok = 1'b1; ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        break;
      end
    end
    check_eq("ovr_lsr_timeout", ok, 1);
    check_eq("ovr_set_wins", rx_overrun, 1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rx_valid) begin ok = 1'b1; break; end
      tick();
    end
    check_eq("rx2_valid_timeout", ok, 1);
    check_eq("rx2_data", rx_data, 8'h20);
    lsr_val = 8'h00;
    repeat (5) tick();
    check_eq("ovr_sticky", rx_overrun, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check_eq("ovr_cleared", rx_overrun, 0);

    // ---- Phase 5: reset during DLM write P phase, init restarts ----
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (uart_wr && uart_a == 3'd1) begin
        ok = 1'b1; rst = 1'b1;
        #1;
        check_eq("mid_rst_cs", uart_cs, 0);
        check_eq("mid_rst_wr", uart_wr, 0);
        break;
      end
    end
    check_eq("dlm_seen", ok, 1);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    n0 = acc_log.size();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (acc_log.size() >= n0 + 6) begin ok = 1'b1; break; end
      tick();
    end
    check_eq("reinit_timeout", ok, 1);
    if (ok) begin
      for (int i = 0; i < 6; i++)
        check_eq("reinit_write", {acc_log[n0+i].wr, acc_log[n0+i].a, acc_log[n0+i].d}, exp_init[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
